// File: rtl/ahb_slave_interface.sv
// AHB slave front end: address/data/write pipeline, range check, peripheral decode.
// Optional error-response FSM is compiled in with `define AHB_ERR_RESP_EN.
module ahb_slave_interface (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hready_in,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] haddr_1,
  output logic [31:0] haddr_2,
  output logic [31:0] hwdata_1,
  output logic [31:0] hwdata_2,
  output logic        hwrite_reg,
  output logic        hwrite_reg_1,
  output logic        valid,
  output logic [2:0]  temp_selx,
  output logic [1:0]  hresp,
  output logic        hready_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] RANGE_LO = 32'h8000_0000;
  localparam logic [AW-1:0] RANGE_HI = 32'h8C00_0000;

  logic in_range;
  logic active_xfer;

  assign in_range    = (haddr >= RANGE_LO) && (haddr < RANGE_HI);
  // NONSEQ and SEQ both have htrans[1] set.
  assign active_xfer = hready_in & htrans[1];

  // Two-stage address/data/write pipeline, advancing only on hready_in.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      haddr_1      <= '0;
      haddr_2      <= '0;
      hwdata_1     <= '0;
      hwdata_2     <= '0;
      hwrite_reg   <= 1'b0;
      hwrite_reg_1 <= 1'b0;
    end else if (hready_in) begin
      haddr_1      <= haddr;
      haddr_2      <= haddr_1;
      hwdata_1     <= hwdata;
      hwdata_2     <= hwdata_1;
      hwrite_reg   <= hwrite;
      hwrite_reg_1 <= hwrite_reg;
    end
  end

  // Peripheral select from the registered address (64 MB windows).
  always_comb begin
    temp_selx = 3'b000;
    unique case (haddr_1[AW-1:AW-6])
      6'b100000: temp_selx = 3'b001;
      6'b100001: temp_selx = 3'b010;
      6'b100010: temp_selx = 3'b100;
      default:   temp_selx = 3'b000;
    endcase
  end

`ifdef AHB_ERR_RESP_EN
  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

  err_state_t state, state_nxt;
  logic       err_det;

  assign err_det = active_xfer & ~in_range;

  always_ff @(posedge hclk) begin
    if (hresetn) state <= ST_OK;
    else         state <= state_nxt;
  end

  // Two-cycle ERROR response; ERR1 ignores the bus, ERR2 may start a new one.
  always_comb begin
    state_nxt  = state;
    hresp      = 2'b00;
    hready_err = 1'b1;
    unique case (state)
      ST_OK: begin
        if (err_det) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        hresp      = 2'b01;
        hready_err = 1'b0;
        state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = 2'b01;
        state_nxt = err_det ? ST_ERR1 : ST_OK;
      end
      default: state_nxt = ST_OK;
    endcase
  end

  assign valid = ~hresetn & active_xfer & in_range & (state != ST_ERR1);
`else
  assign hresp      = 2'b00;
  assign hready_err = 1'b1;
  assign valid      = ~hresetn & active_xfer & in_range;
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed bench for ahb_slave_interface; error-FSM checks follow AHB_ERR_RESP_EN.
module tb_ahb_slave_interface;

  logic        hclk = 1'b0;
  logic        hresetn, hwrite, hready_in;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic [31:0] haddr_1, haddr_2, hwdata_1, hwdata_2;
  logic        hwrite_reg, hwrite_reg_1, valid, hready_err;
  logic [2:0]  temp_selx;
  logic [1:0]  hresp;

  int errors = 0;
  int checks = 0;

  ahb_slave_interface dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
    .haddr_1(haddr_1), .haddr_2(haddr_2), .hwdata_1(hwdata_1), .hwdata_2(hwdata_2),
    .hwrite_reg(hwrite_reg), .hwrite_reg_1(hwrite_reg_1), .valid(valid),
    .temp_selx(temp_selx), .hresp(hresp), .hready_err(hready_err)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        rst, wr, rdy;
    logic [1:0]  tr;
    logic [31:0] addr, data;
    logic        valid;
    logic [31:0] a1, a2, d1, d2;
    logic        w1, w2;
    logic [2:0]  sel;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic rdy, input logic [1:0] tr,
                       input logic [31:0] addr, input logic [31:0] data);
    @(negedge hclk);
    hresetn = rst; hwrite = wr; hready_in = rdy; htrans = tr; haddr = addr; hwdata = data;
    #1;
  endtask

  task automatic clock_edge;
    @(posedge hclk);
    #1;
  endtask

  task automatic check_resp(input string name, input logic [1:0] r, input logic re);
    check({name, "_hresp"}, 32'(hresp), 32'(r));
    check({name, "_hready_err"}, 32'(hready_err), 32'(re));
  endtask

  initial begin
    hresetn = 1'b1; hwrite = 1'b0; hready_in = 1'b0; htrans = 2'b00;
    haddr = '0; hwdata = '0;

    //        rst   wr    rdy   tr     addr          data          vld   a1            a2            d1            d2            w1    w2    sel
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0010, 32'h1111_0000, 1'b1, 32'h8000_0010, 32'h0,        32'h1111_0000, 32'h0,        1'b1, 1'b0, 3'b001};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h8400_0000, 32'hA5A5_0001, 1'b1, 32'h8400_0000, 32'h8000_0010, 32'hA5A5_0001, 32'h1111_0000, 1'b1, 1'b1, 3'b010};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'b11, 32'h8800_0004, 32'hA5A5_0002, 1'b1, 32'h8800_0004, 32'h8400_0000, 32'hA5A5_0002, 32'hA5A5_0001, 1'b0, 1'b1, 3'b100};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b11, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 32'h8800_0004, 32'h8400_0000, 32'hA5A5_0002, 32'hA5A5_0001, 1'b0, 1'b1, 3'b100};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h8000_0000, 32'h0,        1'b0, 32'h8000_0000, 32'h8800_0004, 32'h0,        32'hA5A5_0002, 1'b0, 1'b0, 3'b001};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'b01, 32'h8BFF_FFFC, 32'h2,        1'b0, 32'h8BFF_FFFC, 32'h8000_0000, 32'h2,        32'h0,        1'b1, 1'b0, 3'b100};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h8BFF_FFFF, 32'h3,        1'b1, 32'h8BFF_FFFF, 32'h8BFF_FFFC, 32'h3,        32'h2,        1'b0, 1'b1, 3'b100};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h5,        1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 3'b000};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].rdy, vecs[i].tr, vecs[i].addr, vecs[i].data);
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
      clock_edge();
      check($sformatf("v%0d_haddr_1", i), haddr_1, vecs[i].a1);
      check($sformatf("v%0d_haddr_2", i), haddr_2, vecs[i].a2);
      check($sformatf("v%0d_hwdata_1", i), hwdata_1, vecs[i].d1);
      check($sformatf("v%0d_hwdata_2", i), hwdata_2, vecs[i].d2);
      check($sformatf("v%0d_hwrite_reg", i), 32'(hwrite_reg), 32'(vecs[i].w1));
      check($sformatf("v%0d_hwrite_reg_1", i), 32'(hwrite_reg_1), 32'(vecs[i].w2));
      check($sformatf("v%0d_temp_selx", i), 32'(temp_selx), 32'(vecs[i].sel));
      check_resp($sformatf("v%0d", i), 2'b00, 1'b1);
    end

`ifdef AHB_ERR_RESP_EN
    // Out-of-range NONSEQ: ERR1, ERR2, OK; in-range request during ERR1 is ignored.
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h9000_0000, 32'h4);
    check("e_oor_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("e_err1", 2'b01, 1'b0);
    check("e_err1_haddr_1", haddr_1, 32'h9000_0000);
    check("e_err1_temp_selx", 32'(temp_selx), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h5);
    check("e_err1_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("e_err2", 2'b01, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    check("e_err2_idle_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("e_ok", 2'b00, 1'b1);

    // Upper boundary is exclusive; in-range transfer in ERR2 is accepted.
    drive(1'b0, 1'b0, 1'b1, 2'b11, 32'h8C00_0000, 32'h6);
    check("e_hi_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("e_hi_err1", 2'b01, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    clock_edge();
    check_resp("e_hi_err2", 2'b01, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h8400_0008, 32'h7);
    check("e_err2_inrange_valid", 32'(valid), 32'd1);
    clock_edge();
    check_resp("e_err2_to_ok", 2'b00, 1'b1);
    check("e_err2_temp_selx", 32'(temp_selx), 32'b010);

    // ERR2 with a new error returns to ERR1.
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h7FFF_FFFF, 32'h8);
    check("e_lo_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("e_lo_err1", 2'b01, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    clock_edge();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h9);
    clock_edge();
    check_resp("e_err2_reerr", 2'b01, 1'b0);

    // Reset in ERR1 aborts the response on that edge.
    drive(1'b1, 1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h0);
    check("e_rst_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("e_rst", 2'b00, 1'b1);
    check("e_rst_haddr_1", haddr_1, 32'h0);
`else
    // Out-of-range transfers are dropped with an OKAY response.
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h9000_0000, 32'h4);
    check("d_oor_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("d_oor", 2'b00, 1'b1);
    check("d_oor_haddr_1", haddr_1, 32'h9000_0000);
    check("d_oor_temp_selx", 32'(temp_selx), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 2'b11, 32'h8C00_0000, 32'h5);
    check("d_hi_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("d_hi", 2'b00, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h7FFF_FFFF, 32'h6);
    check("d_lo_valid", 32'(valid), 32'd0);
    clock_edge();
    check_resp("d_lo", 2'b00, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h7);
    check("d_after_valid", 32'(valid), 32'd1);
    clock_edge();
    check("d_after_temp_selx", 32'(temp_selx), 32'b001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_interface.md
AHB_SLAVE_INTERFACE -- requirements
Module: ahb_slave_interface

Interface
REQ-001 SHALL have port hclk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port hresetn, input, 1, reset; synchronous and active-high (asserted when 1).
REQ-003 SHALL have inputs hwrite (1), hready_in (1), htrans (2), haddr (32), hwdata (32): the AHB master signals.
REQ-004 SHALL have outputs haddr_1, haddr_2 (32 each): address pipeline stages 1 and 2.
REQ-005 SHALL have outputs hwdata_1, hwdata_2 (32 each): write-data pipeline stages 1 and 2.
REQ-006 SHALL have outputs hwrite_reg, hwrite_reg_1 (1 each): write-flag pipeline stages 1 and 2.
REQ-007 SHALL have output valid (1): an in-range transfer is being presented to the APB controller.
REQ-008 SHALL have output temp_selx (3): one-hot peripheral select, decoded from haddr_1.
REQ-009 SHALL have outputs hresp (2) and hready_err (1): error response driven to the AHB master.

Function
REQ-010 SHALL load haddr_1<=haddr, hwdata_1<=hwdata and hwrite_reg<=hwrite on an edge where hready_in=1.
REQ-011 SHALL load haddr_2<=haddr_1, hwdata_2<=hwdata_1 and hwrite_reg_1<=hwrite_reg on the same edges.
REQ-012 SHALL hold all pipeline registers when hready_in=0.
REQ-013 SHALL define "in range" as 0x8000_0000 <= haddr < 0x8C00_0000, compared unsigned.
REQ-014 SHALL drive valid combinationally as 1 only when hready_in=1, htrans is 2'b10 or 2'b11, haddr is in range, state is not ERR1, and hresetn=0.
REQ-015 SHALL drive valid=0 for htrans IDLE (00) or BUSY (01), with hresp=OKAY.
REQ-016 SHALL decode temp_selx combinationally from haddr_1:
- 0x8000_0000-0x83FF_FFFF -> 001
- 0x8400_0000-0x87FF_FFFF -> 010
- 0x8800_0000-0x8BFF_FFFF -> 100
- any other address -> 000
REQ-017 SHALL implement error FSM states OK, ERR1, ERR2; err_det = hready_in & htrans[1] & address out of range.
REQ-018 SHALL transition OK->ERR1 on err_det; otherwise remain in OK.
REQ-019 SHALL transition ERR1->ERR2 unconditionally.
REQ-020 SHALL transition ERR2->ERR1 on err_det; otherwise ERR2->OK.
REQ-021 SHALL drive outputs per state:
- OK: hresp=00, hready_err=1
- ERR1: hresp=01, hready_err=0
- ERR2: hresp=01, hready_err=1
REQ-022 SHALL ignore htrans while in ERR1: no valid, no new error.
REQ-023 SHALL process an in-range transfer presented in ERR2 normally (valid=1), with the FSM moving to OK.
REQ-024 SHALL have zero latency from address phase to valid, and pipeline latency of exactly 1 and 2 cycles to stages _1 and _2.

Reset
REQ-025 SHALL, when hresetn=1 at a clock edge, clear every pipeline register to 0 and set the FSM to OK.
REQ-026 SHALL force valid=0 while hresetn=1; hresp=00, hready_err=1 and temp_selx=000 follow from the cleared state.
REQ-027 SHALL abort an in-progress error response on reset mid-ERR1/ERR2, returning to OK on that edge.

Configuration
REQ-028 SHALL, with macro AHB_ERR_RESP_EN defined, include the error FSM as specified in REQ-017 to REQ-023.
REQ-029 SHALL, without AHB_ERR_RESP_EN, omit the FSM: hresp is tied to 00, hready_err to 1, out-of-range transfers are silently dropped (valid=0), and valid does not depend on FSM state.

Verification
REQ-030 SHALL cover: reset, then NONSEQ write haddr=0x8000_0010 hready_in=1 -> valid=1 same cycle; next edge haddr_1=0x8000_0010, temp_selx=001, hwrite_reg=1.
REQ-031 SHALL cover: back-to-back NONSEQ/SEQ to 0x8400_0000 then 0x8800_0004 with hwdata 0xA5A5_0001, 0xA5A5_0002 -> haddr_2/hwdata_2 follow haddr_1/hwdata_1 by one cycle; temp_selx 010 then 100.
REQ-032 SHALL cover: hready_in=0 for 3 cycles mid-burst -> all pipeline registers hold and valid=0.
REQ-033 SHALL cover (EN defined): NONSEQ to 0x9000_0000 -> ERR1 (hresp=01, hready_err=0), then ERR2 (hresp=01, hready_err=1), then OK, with valid=0 throughout.
REQ-034 SHALL cover (EN defined): hresetn=1 asserted while in ERR1 -> next edge hresp=00, hready_err=1, haddr_1=0.
REQ-035 SHALL cover (EN undefined): NONSEQ to 0x9000_0000 -> hresp stays 00, hready_err stays 1, valid=0.
